pipelined_adder_subtractor: RTL
===============================

# pipelined_adder_subtractor

Parametrised, pipelined N-bit adder/subtractor that generalises the team's 4-bit ripple-carry adder. Operands are split into equal chunks, one chunk per pipeline stage, with the carry registered between stages. This sustains one operation per clock at any width. A valid/ready handshake on both sides lets the block sit directly in the datapath between a producer and a possibly back-pressuring consumer. It adds a subtract mode and a signed-overflow flag, which the 4-bit ripple adder does not have.

## Interface
- WIDTH, 16: operand/result width in bits; must be ≥ 1.
- STAGES, 4: pipeline depth and chunk count; WIDTH mod STAGES must be 0; chunk width CW = WIDTH/STAGES.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (subtract).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out; in subtract mode 1 = no borrow.
- ovf  out  1  signed (two's complement) overflow.

## Operation
- Transfer in: rising edge with in_valid && in_ready. Transfer out: rising edge with out_valid && out_ready.
- Arithmetic:
  - Add: {cout,sum} = a + b + cin.
  - Subtract: {cout,sum} = a + ~b + ~cin, which gives a − b − cin (cin acts as borrow).
  - Computed modulo 2^WIDTH; cout is bit WIDTH of the (WIDTH+1)-bit result.
  - ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff = sub ? ~b : b.
- Pipeline structure:
  - Stage k (0..STAGES−1) adds chunk k of a and b_eff plus the carry registered by stage k−1. Stage 0 uses the effective carry-in, sub ? ~cin : cin.
  - Upper operand chunks are skew-delayed so they reach their stage together with the carry.
  - Lower result chunks are de-skew-delayed so all WIDTH bits leave together.
  - a_msb and b_eff_msb travel with the operation so ovf is formed in the last stage.
- One valid bit per stage marks occupancy; empty stages (bubbles) carry no result and are never presented.
- Flow control is a global stall:
  - stall = out_valid && !out_ready.
  - While stalled, every stage register, valid bit and skew register holds.
  - in_ready = !stall (combinational; no combinational path from in_valid).
- sum, cout and ovf are registered outputs from the final stage. They stay stable while out_valid && !out_ready.
- When out_valid = 0, the values on sum/cout/ovf are don't-care; verification must not check them.
- Results leave in acceptance order; none is lost or duplicated.
- STAGES = 1 reduces to a single registered full-width adder with the same handshake.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert expected):
  - All valid bits → 0, so out_valid = 0 immediately on assert.
  - sum, cout, ovf and all internal data and carry registers → 0.
  - in_ready = 1 while rst is high and after release (stall = 0).
- Latency: an operation accepted at edge E appears with out_valid = 1 just after edge E+STAGES−1, i.e. STAGES cycles from in_valid sampling to result, with no stalls.
- Throughput: one operation per cycle while out_ready = 1.
- Stall of n cycles adds exactly n cycles to every in-flight operation. A bubble in the pipeline does not let the stall be absorbed (no bubble collapsing).
- Simultaneous in and out transfers in the same cycle are allowed.
- The output register is reloaded with the next result or a bubble (out_valid = 0) on the same edge the current result transfers.
- Reset mid-operation: all in-flight operations are discarded. The first out_valid after release belongs to an operation accepted after release.

## Test plan
- WIDTH=16, STAGES=4, add: a=0xFFFF, b=0x0000, cin=1 → after 4 cycles sum=0x0000, cout=1, ovf=0 (carry ripples through all four chunks).
- Add overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Back-pressure: 8 random operations back-to-back with out_ready held low for 3 cycles while the first result is presented → in_ready low exactly those 3 cycles; sum/cout/ovf held stable; all 8 results correct, in order, none duplicated.
- Bubbles and reset: alternate in_valid 1/0 for 6 cycles, then assert rst with 2 operations in flight → out_valid=0 immediately; no stale result after release; a following operation returns with 4-cycle latency.
- STAGES=1 and WIDTH=8, STAGES=2: 200 random add/sub operations with random in_valid/out_ready → every result matches the reference arithmetic (sum, cout, ovf).

Source files
------------

// File: rtl/pipelined_adder_subtractor.sv
// pipelined_adder_subtractor
//   Chunked, pipelined WIDTH-bit adder/subtractor. Each of the STAGES stages adds one
//   CW = WIDTH/STAGES bit chunk and registers its carry for the next stage. Upper operand
//   chunks ride along (skew) and finished lower result chunks ride along (de-skew) so the
//   whole result leaves the last stage together. A single global stall freezes the pipe
//   whenever the output is presented but not accepted.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set presented
//   in_ready   out  operands accepted this cycle (low only while stalled)
//   a, b       in   operands
//   cin        in   carry-in (add) / borrow-in (subtract)
//   sub        in   0 = add, 1 = subtract
//   out_valid  out  result presented
//   out_ready  in   consumer accepts result
//   sum        out  result
//   cout       out  carry-out (subtract: 1 = no borrow)
//   ovf        out  two's complement overflow
//
// WIDTH must be >= 1 and a multiple of STAGES.

module pipelined_adder_subtractor #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    // Per-stage state. Stage k holds result chunks 0..k and the operand chunks still to be
    // added by later stages; the other bits of a_q/b_q/sum_q are simply not looked at.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [STAGES-1:0] a_msb_q, a_msb_d;
    logic [STAGES-1:0] b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;

    logic              stall;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

    // Global stall: the whole pipe freezes, bubbles included, so every in-flight
    // operation is delayed by exactly the stall length.
    assign stall    = valid_q[STAGES-1] & ~out_ready;
    assign in_ready = ~stall;

    // Subtract as a + ~b + ~cin, so cin acts as an active-high borrow.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;

    always_comb begin
        logic [CW:0] chunk;

        valid_d = valid_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        chunk   = '0;

        if (!stall) begin
            // Stage 0 works straight from the inputs.
            chunk = {1'b0, a[CW-1:0]} + {1'b0, b_eff[CW-1:0]} + {{CW{1'b0}}, cin_eff};
            valid_d[0]          = in_valid;
            a_d[0]              = a;
            b_d[0]              = b_eff;
            sum_d[0]            = '0;
            sum_d[0][CW-1:0]    = chunk[CW-1:0];
            carry_d[0]          = chunk[CW];
            a_msb_d[0]          = a[WIDTH-1];
            b_msb_d[0]          = b_eff[WIDTH-1];

            // Stage k adds chunk k of the skewed operands plus the carry from stage k-1.
            for (int k = 1; k < int'(STAGES); k++) begin
                chunk = {1'b0, a_q[k-1][k*CW +: CW]}
                      + {1'b0, b_q[k-1][k*CW +: CW]}
                      + {{CW{1'b0}}, carry_q[k-1]};
                valid_d[k]             = valid_q[k-1];
                a_d[k]                 = a_q[k-1];
                b_d[k]                 = b_q[k-1];
                sum_d[k]               = sum_q[k-1];
                sum_d[k][k*CW +: CW]   = chunk[CW-1:0];
                carry_d[k]             = chunk[CW];
                a_msb_d[k]             = a_msb_q[k-1];
                b_msb_d[k]             = b_msb_q[k-1];
            end

            // Overflow is formed alongside the last stage so it is registered with sum.
            ovf_d = (a_msb_d[STAGES-1] == b_msb_d[STAGES-1])
                 && (sum_d[STAGES-1][WIDTH-1] != a_msb_d[STAGES-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_msb_q <= '0;
            b_msb_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
